// File: rtl/mem_responder_pkg.sv
// Shared constants and request decoding for the main-memory responder.
package mem_responder_pkg;

    localparam int unsigned MEM_LATENCY = 4;
    localparam int unsigned MEM_WORD_W  = 16;
    localparam int unsigned MEM_IDX_W   = 15;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned PEND_W      = 4;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2
    } req_kind_e;

    function automatic req_kind_e decode_req(input logic enable, input logic wr);
        if (!enable) return REQ_IDLE;
        return wr ? REQ_WRITE : REQ_READ;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Fixed-latency valid+data delay line; never stalls, cleared asynchronously.
module mem_rd_pipe
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = MEM_LATENCY,
    parameter int unsigned WORD_W  = MEM_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data
);

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic [WORD_W-1:0]  dat_q [LATENCY];
    logic [WORD_W-1:0]  dat_d [LATENCY];

    // Invalid slots carry zero data so the output needs no gating.
    always_comb begin
        vld_d    = '0;
        dat_d    = '{default: '0};
        vld_d[0] = in_valid;
        dat_d[0] = in_valid ? in_data : '0;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '{default: '0};
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed main memory with fully pipelined fixed-latency reads.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WORD_W  = MEM_WORD_W,
    parameter int unsigned IDX_W   = MEM_IDX_W,
    parameter int unsigned LATENCY = MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic [15:0]       addr,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic [3:0]        pending
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    req_kind_e         req_kind_c;
    logic [IDX_W-1:0]  idx_c;
    logic [WORD_W-1:0] rd_word_c;
    logic              rd_acc_c;
    logic              unused_addr_c;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [PEND_W-1:0] pending_q;
    logic [PEND_W-1:0] pending_d;

    assign req_kind_c    = decode_req(enable, wr);
    assign rd_acc_c      = (req_kind_c == REQ_READ);
    assign idx_c         = addr[IDX_W:1];
    assign rd_word_c     = mem[idx_c];
    assign unused_addr_c = ^addr;

    // Storage is not reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (req_kind_c == REQ_WRITE) begin
            mem[idx_c] <= data_in;
        end
    end

    mem_rd_pipe #(
        .LATENCY (LATENCY),
        .WORD_W  (WORD_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_acc_c),
        .in_data   (rd_word_c),
        .out_valid (data_valid),
        .out_data  (data_out)
    );

    always_comb begin
        pending_d = pending_q + PEND_W'(rd_acc_c) - PEND_W'(data_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed + randomized bench for mem_responder against a queue-based reference model.
module tb_mem_responder;

    localparam int LAT = 4;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic        wr      = 1'b0;
    logic [15:0] addr    = '0;
    logic [15:0] data_in = '0;

    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  pending;
    logic [15:0] a_data_out;
    logic        a_data_valid;
    logic [3:0]  a_pending;

    mem_responder #(.WORD_W(16), .IDX_W(15), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .pending    (pending)
    );

    // Narrower index so that addr bit 15 is ignored and aliases.
    mem_responder #(.WORD_W(16), .IDX_W(14), .LATENCY(LAT)) dut_alias (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (a_data_out),
        .data_valid (a_data_valid),
        .pending    (a_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model [int];
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          peak   = 0;

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % 32768;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic check_cycle();
        logic        ev;
        logic [15:0] ed;
        ev = 1'b0;
        ed = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev = 1'b1;
            ed = exp_q[0].d;
        end
        if (int'(pending) > peak) peak = int'(pending);
        chk("pending", 32'(pending), 32'(exp_q.size()));
        chk("data_valid", 32'(data_valid), 32'(ev));
        chk("data_out", 32'(data_out), 32'(ed));
        if (ev) void'(exp_q.pop_front());
    endtask

    // One request cycle: drive at negedge, update model at the edge, check at the next negedge.
    task automatic step(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        if (en && !w && rst_n) begin
            e.due = cyc + LAT;
            e.d   = model[widx(a)];
            exp_q.push_back(e);
        end
        if (en && w) model[widx(a)] = d;
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        // Reset held with a read request pending on the port.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0020, 16'h0000);
        rst_n = 1'b1;

        // Single read.
        step(1'b1, 1'b1, 16'h0020, 16'hBEEF);
        step(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(6);

        // Block fill.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'(16'h0080 + 2 * i), 16'(16'h1000 + i));
        peak = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(16'h0080 + 2 * i), 16'h0000);
        idle(6);
        chk("fill_peak_pending", 32'(peak), 32'd4);

        // Read-after-write with bit 0 set on the read.
        step(1'b1, 1'b1, 16'h0100, 16'hA5A5);
        step(1'b1, 1'b0, 16'h0101, 16'h0000);
        idle(6);

        // Reset mid-flight discards everything in the pipe.
        step(1'b1, 1'b0, 16'h0080, 16'h0000);
        step(1'b1, 1'b0, 16'h0082, 16'h0000);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_async_valid", 32'(data_valid), 32'd0);
        chk("rst_async_pending", 32'(pending), 32'd0);
        chk("rst_async_data", 32'(data_out), 32'd0);
        step(1'b1, 1'b0, 16'h0084, 16'h0000);
        rst_n = 1'b1;
        idle(6);
        step(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(6);

        // Bubble between two reads.
        step(1'b1, 1'b0, 16'h0080, 16'h0000);
        idle(1);
        step(1'b1, 1'b0, 16'h0082, 16'h0000);
        idle(6);

        // Alias: distinct word at IDX_W=15, aliased word at IDX_W=14.
        step(1'b1, 1'b1, 16'h8002, 16'h5678);
        step(1'b1, 1'b1, 16'h0002, 16'h1234);
        step(1'b1, 1'b0, 16'h8002, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) idle(1);
            chk("alias_valid", 32'(a_data_valid), 32'(k == 4));
            chk("alias_data", 32'(a_data_out), (k == 4) ? 32'h1234 : 32'h0);
        end
        idle(4);

        // Randomized mix over a preloaded window.
        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 16'((16'h0200 + i) * 2), 16'($urandom));
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0),
                 16'((16'h0200 + $urandom_range(0, 63)) * 2 + $urandom_range(0, 1)),
                 16'($urandom));
        end
        idle(6);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
